// File: rtl/sync_up_counter.sv
// -----------------------------------------------------------------------------
// sync_up_counter
//   Synchronous modulo-MODULUS up counter used as a timebase / sequence
//   generator. Every flop shares one clock, so all bits change together.
//   Supports synchronous clear, parallel load (with illegal-value detection),
//   count enable, a combinational terminal-count flag for cascading and a
//   registered one-cycle wrap pulse.
//
//   Priority on each rising edge: reset > clear > load > enable > hold.
//
// Parameters
//   WIDTH        counter width in bits
//   MODULUS      count sequence 0..MODULUS-1, legal range 2..2**WIDTH
//   RESET_VALUE  count after reset, must be < MODULUS
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   synchronous active-high reset
//   clear       in   synchronous clear to 0
//   load        in   parallel load strobe
//   load_value  in   [WIDTH] value loaded when load=1
//   enable      in   count enable
//   counter     out  [WIDTH] current count (registered)
//   tc          out  terminal count (combinational), usable as the enable of
//                    a cascaded stage
//   wrap        out  registered one-cycle pulse after a MODULUS-1 -> 0 wrap
//   load_err    out  registered one-cycle pulse after a load of a value that
//                    is >= MODULUS (counter is loaded with MODULUS-1 instead)
//
// Build option
//   SYNC_UP_COUNTER_SATURATE_EN
//     defined   : the counter sticks at MODULUS-1 instead of wrapping; wrap
//                 never pulses; tc still asserts (acts as a "full" flag).
//                 Only load, clear or reset leave saturation.
//     undefined : modulo wrap (default build).
// -----------------------------------------------------------------------------
module sync_up_counter #(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 16,
  parameter int RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

`ifdef SYNC_UP_COUNTER_SATURATE_EN
  localparam bit LP_SATURATE = 1'b1;
`else
  localparam bit LP_SATURATE = 1'b0;
`endif

  // Terminal value as a WIDTH-bit constant; for MODULUS == 2**WIDTH this is
  // all ones, giving natural binary rollover.
  localparam logic [WIDTH-1:0] LP_MAX   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LP_RST_V = WIDTH'(RESET_VALUE);
  // One extra bit so MODULUS == 2**WIDTH is representable in the compare.
  localparam int               LP_CW    = WIDTH + 1;

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_load_err;

  logic             w_at_max;
  logic             w_load_illegal;

  // Next count on an enabled edge: wrap (or saturate) at the terminal value.
  function automatic logic [WIDTH-1:0] f_next_count(input logic [WIDTH-1:0] cnt);
    logic [WIDTH-1:0] nxt;
    nxt = cnt + WIDTH'(1);
    if (cnt == LP_MAX) begin
      nxt = LP_SATURATE ? LP_MAX : '0;
    end
    return nxt;
  endfunction

  // Loaded values outside 0..MODULUS-1 are clamped to the terminal value.
  function automatic logic f_load_out_of_range(input logic [WIDTH-1:0] v);
    return (LP_CW'(v) >= LP_CW'(MODULUS));
  endfunction

  function automatic logic [WIDTH-1:0] f_clamp_load(input logic [WIDTH-1:0] v);
    return f_load_out_of_range(v) ? LP_MAX : v;
  endfunction

  assign w_at_max       = (r_count == LP_MAX);
  assign w_load_illegal = f_load_out_of_range(load_value);

  // tc predicts the wrapping edge, so it is only high when enable is the
  // action that will actually win this edge.
  assign tc = enable & w_at_max & ~load & ~clear & ~reset;

  // Count register plus the two pulse flops
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count    <= LP_RST_V;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else if (clear) begin
      r_count    <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else if (load) begin
      r_count    <= f_clamp_load(load_value);
      r_wrap     <= 1'b0;
      r_load_err <= w_load_illegal;
    end else if (enable) begin
      r_count    <= f_next_count(r_count);
      r_wrap     <= w_at_max & ~LP_SATURATE;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end
  end

  assign counter  = r_count;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_sync_up_counter.sv
module tb_sync_up_counter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: WIDTH=4, MODULUS=10
  logic       a_reset = 1'b0, a_clear = 1'b0, a_load = 1'b0, a_enable = 1'b0;
  logic [3:0] a_lv = 4'd0;
  logic [3:0] a_cnt;
  logic       a_tc, a_wrap, a_lerr;

  // Instance B: WIDTH=4, MODULUS=16
  logic       b_reset = 1'b0, b_clear = 1'b0, b_load = 1'b0, b_enable = 1'b0;
  logic [3:0] b_lv = 4'd0;
  logic [3:0] b_cnt;
  logic       b_tc, b_wrap, b_lerr;

  // Cascade: two MODULUS=16 stages, upper enabled by lower tc
  logic       c_reset = 1'b0, c_clear = 1'b0, c_load = 1'b0, c_en = 1'b0;
  logic [3:0] c_lv = 4'd0;
  logic [3:0] c_lo_cnt, c_hi_cnt;
  logic       c_lo_tc, c_lo_wrap, c_lo_lerr;
  logic       c_hi_tc, c_hi_wrap, c_hi_lerr;

  sync_up_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dut_a (
    .clock(clock), .reset(a_reset), .clear(a_clear), .load(a_load),
    .load_value(a_lv), .enable(a_enable), .counter(a_cnt), .tc(a_tc),
    .wrap(a_wrap), .load_err(a_lerr)
  );

  sync_up_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) dut_b (
    .clock(clock), .reset(b_reset), .clear(b_clear), .load(b_load),
    .load_value(b_lv), .enable(b_enable), .counter(b_cnt), .tc(b_tc),
    .wrap(b_wrap), .load_err(b_lerr)
  );

  sync_up_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) dut_lo (
    .clock(clock), .reset(c_reset), .clear(c_clear), .load(c_load),
    .load_value(c_lv), .enable(c_en), .counter(c_lo_cnt), .tc(c_lo_tc),
    .wrap(c_lo_wrap), .load_err(c_lo_lerr)
  );

  sync_up_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) dut_hi (
    .clock(clock), .reset(c_reset), .clear(c_clear), .load(c_load),
    .load_value(c_lv), .enable(c_lo_tc), .counter(c_hi_cnt), .tc(c_hi_tc),
    .wrap(c_hi_wrap), .load_err(c_hi_lerr)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    a_reset = 1'b1; a_enable = 1'b1;
    b_reset = 1'b1; c_reset = 1'b1;
    tick();
    tick();
    n_vec++; if (a_cnt !== 4'd0) begin $display("FAIL rst_cnt got %0d exp 0", a_cnt); n_err++; end
    n_vec++; if (a_wrap !== 1'b0) begin $display("FAIL rst_wrap got %b exp 0", a_wrap); n_err++; end
    n_vec++; if (a_lerr !== 1'b0) begin $display("FAIL rst_lerr got %b exp 0", a_lerr); n_err++; end
    n_vec++; if (a_tc !== 1'b0) begin $display("FAIL rst_tc got %b exp 0", a_tc); n_err++; end
    n_vec++; if (b_cnt !== 4'd0) begin $display("FAIL rst_b_cnt got %0d exp 0", b_cnt); n_err++; end
    n_vec++; if (c_hi_cnt !== 4'd0) begin $display("FAIL rst_hi_cnt got %0d exp 0", c_hi_cnt); n_err++; end
    a_reset = 1'b0; a_enable = 1'b0;
    b_reset = 1'b0; c_reset = 1'b0;
    #1;
  endtask

  task automatic test_count();
    int e;
    a_enable = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      e = i % 10;
      n_vec++; if (a_cnt !== 4'(e)) begin $display("FAIL cnt_seq[%0d] got %0d exp %0d", i, a_cnt, e); n_err++; end
      n_vec++; if (a_tc !== (e == 9)) begin $display("FAIL cnt_tc[%0d] got %b exp %b", i, a_tc, (e == 9)); n_err++; end
      n_vec++; if (a_wrap !== (i == 10)) begin $display("FAIL cnt_wrap[%0d] got %b exp %b", i, a_wrap, (i == 10)); n_err++; end
      tick();
    end
    a_enable = 1'b0;
    n_vec++; if (a_cnt !== 4'd2) begin $display("FAIL cnt_end got %0d exp 2", a_cnt); n_err++; end
  endtask

  task automatic test_hold();
    int en_seq [4] = '{1, 0, 0, 1};
    int exp_c  [4] = '{4, 4, 4, 5};
    a_load = 1'b1; a_lv = 4'd3;
    tick();
    a_load = 1'b0;
    n_vec++; if (a_cnt !== 4'd3) begin $display("FAIL hold_pre got %0d exp 3", a_cnt); n_err++; end
    for (int i = 0; i < 4; i++) begin
      a_enable = (en_seq[i] != 0);
      tick();
      n_vec++; if (a_cnt !== 4'(exp_c[i])) begin $display("FAIL hold[%0d] got %0d exp %0d", i, a_cnt, exp_c[i]); n_err++; end
    end
    a_enable = 1'b0;
    n_vec++; if (a_wrap !== 1'b0) begin $display("FAIL hold_wrap got %b exp 0", a_wrap); n_err++; end
  endtask

  task automatic test_load();
    a_load = 1'b1; a_lv = 4'd7; a_enable = 1'b1;
    tick();
    n_vec++; if (a_cnt !== 4'd7) begin $display("FAIL load7 got %0d exp 7", a_cnt); n_err++; end
    n_vec++; if (a_lerr !== 1'b0) begin $display("FAIL load7_err got %b exp 0", a_lerr); n_err++; end
    a_lv = 4'd12;
    tick();
    n_vec++; if (a_cnt !== 4'd9) begin $display("FAIL load12 got %0d exp 9", a_cnt); n_err++; end
    n_vec++; if (a_lerr !== 1'b1) begin $display("FAIL load12_err got %b exp 1", a_lerr); n_err++; end
    a_load = 1'b0; a_enable = 1'b0;
    tick();
    n_vec++; if (a_cnt !== 4'd9) begin $display("FAIL load_hold got %0d exp 9", a_cnt); n_err++; end
    n_vec++; if (a_lerr !== 1'b0) begin $display("FAIL load_err_pulse got %b exp 0", a_lerr); n_err++; end
    a_enable = 1'b1; a_load = 1'b1; a_lv = 4'd2;
    #1;
    n_vec++; if (a_tc !== 1'b0) begin $display("FAIL load_tc got %b exp 0", a_tc); n_err++; end
    tick();
    n_vec++; if (a_cnt !== 4'd2) begin $display("FAIL load2 got %0d exp 2", a_cnt); n_err++; end
    n_vec++; if (a_wrap !== 1'b0) begin $display("FAIL load2_wrap got %b exp 0", a_wrap); n_err++; end
    a_load = 1'b0; a_enable = 1'b0;
  endtask

  task automatic test_priority();
    a_load = 1'b1; a_lv = 4'd9;
    tick();
    a_load = 1'b0; a_enable = 1'b1;
    #1;
    n_vec++; if (a_tc !== 1'b1) begin $display("FAIL prio_tc9 got %b exp 1", a_tc); n_err++; end
    a_reset = 1'b1;
    #1;
    n_vec++; if (a_tc !== 1'b0) begin $display("FAIL prio_tc_rst got %b exp 0", a_tc); n_err++; end
    tick();
    n_vec++; if (a_cnt !== 4'd0) begin $display("FAIL prio_rst_cnt got %0d exp 0", a_cnt); n_err++; end
    n_vec++; if (a_wrap !== 1'b0) begin $display("FAIL prio_rst_wrap got %b exp 0", a_wrap); n_err++; end
    a_reset = 1'b0; a_enable = 1'b0;
    a_load = 1'b1; a_lv = 4'd15;
    tick();
    n_vec++; if (a_lerr !== 1'b1) begin $display("FAIL prio_lerr got %b exp 1", a_lerr); n_err++; end
    a_clear = 1'b1; a_lv = 4'd7; a_enable = 1'b1;
    #1;
    n_vec++; if (a_tc !== 1'b0) begin $display("FAIL prio_tc_clr got %b exp 0", a_tc); n_err++; end
    tick();
    n_vec++; if (a_cnt !== 4'd0) begin $display("FAIL prio_clr_cnt got %0d exp 0", a_cnt); n_err++; end
    n_vec++; if (a_lerr !== 1'b0) begin $display("FAIL prio_clr_lerr got %b exp 0", a_lerr); n_err++; end
    a_clear = 1'b0; a_load = 1'b0; a_enable = 1'b0;
  endtask

  task automatic test_mod16();
    int e;
    b_enable = 1'b1;
    #1;
    for (int i = 0; i <= 16; i++) begin
      e = i % 16;
      n_vec++; if (b_cnt !== 4'(e)) begin $display("FAIL m16_cnt[%0d] got %0d exp %0d", i, b_cnt, e); n_err++; end
      n_vec++; if (b_tc !== (e == 15)) begin $display("FAIL m16_tc[%0d] got %b exp %b", i, b_tc, (e == 15)); n_err++; end
      n_vec++; if (b_wrap !== (i == 16)) begin $display("FAIL m16_wrap[%0d] got %b exp %b", i, b_wrap, (i == 16)); n_err++; end
      tick();
    end
    b_enable = 1'b0;
    tick();
    n_vec++; if (b_cnt !== 4'd1) begin $display("FAIL m16_hold got %0d exp 1", b_cnt); n_err++; end
    n_vec++; if (b_wrap !== 1'b0) begin $display("FAIL m16_wrap_end got %b exp 0", b_wrap); n_err++; end
  endtask

  task automatic test_cascade();
    c_en = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      n_vec++; if (c_lo_cnt !== 4'(i % 16)) begin $display("FAIL casc_lo[%0d] got %0d exp %0d", i, c_lo_cnt, i % 16); n_err++; end
      n_vec++; if (c_hi_cnt !== 4'(i / 16)) begin $display("FAIL casc_hi[%0d] got %0d exp %0d", i, c_hi_cnt, i / 16); n_err++; end
    end
    c_en = 1'b0;
  endtask

  task automatic test_saturate();
    int e;
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0; a_enable = 1'b1;
    #1;
    for (int i = 0; i < 15; i++) begin
      e = (i < 9) ? i : 9;
      n_vec++; if (a_cnt !== 4'(e)) begin $display("FAIL sat_cnt[%0d] got %0d exp %0d", i, a_cnt, e); n_err++; end
      n_vec++; if (a_tc !== (e == 9)) begin $display("FAIL sat_tc[%0d] got %b exp %b", i, a_tc, (e == 9)); n_err++; end
      n_vec++; if (a_wrap !== 1'b0) begin $display("FAIL sat_wrap[%0d] got %b exp 0", i, a_wrap); n_err++; end
      tick();
    end
    n_vec++; if (a_cnt !== 4'd9) begin $display("FAIL sat_end got %0d exp 9", a_cnt); n_err++; end
    a_clear = 1'b1;
    tick();
    n_vec++; if (a_cnt !== 4'd0) begin $display("FAIL sat_clr got %0d exp 0", a_cnt); n_err++; end
    a_clear = 1'b0; a_enable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    test_reset();
`ifdef SYNC_UP_COUNTER_SATURATE_EN
    test_saturate();
`else
    test_count();
    test_mod16();
    test_cascade();
`endif
    test_hold();
    test_load();
    test_priority();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
